// File: rtl/dice_pkg.sv
// Shared types and 7-segment encodings for the dice roller.
// Segment codes are active-low with bit order g..a.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DASH = 7'b011_1111;
  localparam logic [6:0] SEG_1    = 7'b111_1001;
  localparam logic [6:0] SEG_2    = 7'b010_0100;
  localparam logic [6:0] SEG_3    = 7'b011_0000;
  localparam logic [6:0] SEG_4    = 7'b001_1001;
  localparam logic [6:0] SEG_5    = 7'b001_0010;
  localparam logic [6:0] SEG_6    = 7'b000_0010;
  localparam logic [6:0] SEG_7    = 7'b111_1000;
  localparam logic [6:0] SEG_8    = 7'b000_0000;
  localparam logic [6:0] SEG_9    = 7'b001_0000;
  localparam logic [6:0] SEG_F    = 7'b000_1110;

  function automatic logic [6:0] face_to_seg(input logic [3:0] face);
    case (face)
      4'd1:    face_to_seg = SEG_1;
      4'd2:    face_to_seg = SEG_2;
      4'd3:    face_to_seg = SEG_3;
      4'd4:    face_to_seg = SEG_4;
      4'd5:    face_to_seg = SEG_5;
      4'd6:    face_to_seg = SEG_6;
      4'd7:    face_to_seg = SEG_7;
      4'd8:    face_to_seg = SEG_8;
      4'd9:    face_to_seg = SEG_9;
      default: face_to_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Button synchroniser, debouncer and registered press/release pulses.
// Latency: 2 sync + DEBOUNCE_CYCLES to stable, +1 to the pulse; no backpressure.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic stable,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      stable        <= 1'b0;
      stable_q      <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      // The level must differ for DEBOUNCE_CYCLES consecutive samples to flip.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      stable_q      <= stable;
      press_pulse   <= stable & ~stable_q;
      release_pulse <= ~stable & stable_q;
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Multi-die roller: odometer face counters, button FSM, registered 7-seg and sum outputs.
// Outputs change one clock after a press/release pulse; no backpressure.
module dice_roller
  import dice_pkg::*;
#(
  parameter int N_DICE          = 2,
  parameter int FACES           = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 number_catch,
  output logic [7*N_DICE-1:0]                  segments,
  output logic [$clog2(N_DICE*FACES+1)-1:0]    roll_sum,
  output logic                                 roll_valid,
  output logic                                 rolling
);

  localparam int SW = $clog2(N_DICE*FACES+1);
  localparam logic [3:0] FACE_MAX = 4'(FACES);

  state_t state;
  state_t state_next;

  logic [N_DICE-1:0][3:0] dice;
  logic [N_DICE-1:0][3:0] dice_next;
  logic [N_DICE-1:0][3:0] held;
  logic [N_DICE-1:0][3:0] held_next;
  logic [7*N_DICE-1:0]    seg_next;
  logic [SW-1:0]          sum_next;
  logic                   step;
  logic                   stable_unused;
  logic                   press;
  logic                   release_pulse;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .clk          (clk),
    .reset        (reset),
    .button       (number_catch),
    .stable       (stable_unused),
    .press_pulse  (press),
    .release_pulse(release_pulse)
  );

  // Odometer: die k advances only when every lower die is at FACES.
  always_comb begin
    dice_next = dice;
    step      = 1'b1;
    for (int k = 0; k < N_DICE; k++) begin
      if (step) begin
        dice_next[k] = (dice[k] == FACE_MAX) ? 4'd1 : dice[k] + 4'd1;
      end
      step = step && (dice[k] == FACE_MAX);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (press)         state_next = ROLL;
      ROLL:    if (release_pulse) state_next = SHOW;
      SHOW:    if (press)         state_next = ROLL;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign held_next = (state == ROLL && release_pulse) ? dice : held;

  // Outputs are precomputed from next-state values so they switch with the state.
  always_comb begin
    seg_next = '0;
    sum_next = '0;
    for (int k = 0; k < N_DICE; k++) begin
      case (state_next)
        ROLL:    seg_next[7*k +: 7] = face_to_seg(dice_next[k]);
        SHOW:    seg_next[7*k +: 7] = face_to_seg(held_next[k]);
        default: seg_next[7*k +: 7] = SEG_DASH;
      endcase
      if (state_next != IDLE) begin
        sum_next = sum_next + SW'(held_next[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dice       <= {N_DICE{4'd1}};
      held       <= {N_DICE{4'd1}};
      segments   <= {N_DICE{SEG_DASH}};
      roll_sum   <= '0;
      roll_valid <= 1'b0;
      rolling    <= 1'b0;
    end else begin
      dice       <= dice_next;
      held       <= held_next;
      segments   <= seg_next;
      roll_sum   <= sum_next;
      roll_valid <= (state_next == SHOW) && (state != SHOW);
      rolling    <= (state_next == ROLL);
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller (N_DICE=2, FACES=6, DEBOUNCE_CYCLES=4).
// Cycle k counts clocks since the last reset edge; die faces follow k from the odometer rule.
module tb_dice_roller;

  localparam int N_DICE = 2;
  localparam int FACES  = 6;
  localparam int DB     = 4;
  localparam logic [13:0] DASH2 = 14'b0111111_0111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        number_catch;
  logic [13:0] segments;
  logic [3:0]  roll_sum;
  logic        roll_valid;
  logic        rolling;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  dice_roller #(
    .N_DICE         (N_DICE),
    .FACES          (FACES),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .number_catch(number_catch),
    .segments    (segments),
    .roll_sum    (roll_sum),
    .roll_valid  (roll_valid),
    .rolling     (rolling)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 400 && cyc != target; i++) step();
    check("reach_cycle", cyc, target);
  endtask

  function automatic logic [6:0] seg_of(input int f);
    case (f)
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic int die0_at(input int k);
    return (k % FACES) + 1;
  endfunction

  function automatic int die1_at(input int k);
    return ((k / FACES) % FACES) + 1;
  endfunction

  function automatic logic [13:0] live_seg(input int k);
    return {seg_of(die1_at(k)), seg_of(die0_at(k))};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    number_catch = 1'b0;
    repeat (3) step();

    check("rst_segments", segments, DASH2);
    check("rst_roll_sum", roll_sum, 0);
    check("rst_roll_valid", roll_valid, 0);
    check("rst_rolling", rolling, 0);
    reset = 1'b0;

    // Odometer sequence, including die1 wrapping 6->1 at k=36.
    for (int k = 0; k < 40; k++) begin
      check("chain", dut.dice, {4'(die1_at(k)), 4'(die0_at(k))});
      step();
    end

    // 3-cycle glitch is one short of the debounce window.
    step();
    number_catch = 1'b1;
    repeat (3) step();
    number_catch = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("glitch_rolling", rolling, 0);
      check("glitch_segments", segments, DASH2);
      step();
    end

    // Clean press at 63: ROLL 8 clocks later; release at 73 captures cycle 80 (die1=2, die0=3).
    run_to(63);
    number_catch = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("press_rolling", rolling, (cyc >= 71));
      step();
    end
    number_catch = 1'b0;
    for (int i = 0; i < 13; i++) begin
      check("rel1_rolling", rolling, (cyc < 81));
      check("rel1_valid", roll_valid, (cyc == 81));
      if (cyc == 75) begin
        check("roll1_live_seg", segments, live_seg(cyc));
        check("roll1_sum_init", roll_sum, 2);
      end
      if (cyc == 81) begin
        check("show1_segments", segments, 14'b0100100_0110000);
        check("show1_sum", roll_sum, 5);
      end
      step();
    end

    // Second roll from SHOW; release at 100 captures cycle 107 (6,6).
    run_to(90);
    number_catch = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("press2_rolling", rolling, (cyc >= 98));
      if (cyc >= 98) begin
        check("roll2_sum_held", roll_sum, 5);
        check("roll2_live_seg", segments, live_seg(cyc));
      end
      step();
    end
    number_catch = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check("rel2_rolling", rolling, (cyc < 108));
      check("rel2_valid", roll_valid, (cyc == 108));
      if (cyc == 108) begin
        check("show2_segments", segments, 14'b0000010_0000010);
        check("show2_sum", roll_sum, 12);
      end
      step();
    end

    // Reset in the middle of a roll with the button still held.
    run_to(120);
    number_catch = 1'b1;
    run_to(130);
    check("roll3_rolling", rolling, 1);
    reset = 1'b1;
    step();
    check("midrst_rolling", rolling, 0);
    check("midrst_segments", segments, DASH2);
    check("midrst_sum", roll_sum, 0);
    check("midrst_valid", roll_valid, 0);
    number_catch = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("post_rst_valid", roll_valid, 0);
      check("post_rst_rolling", rolling, 0);
      check("post_rst_segments", segments, DASH2);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
